// File: rtl/conv_win_seq.sv
// rtl/conv_win_seq.sv - bit-plane 3x3 window sequencer feeding the OPU
//
// Loads one square picture as bit-serial planes (BITS beats of DW lanes per
// pixel, plane 0 first, row-major by pixel). It then replays every 3x3 window
// as BITS beats of 9*DW bits under valid/ready. Zero padding, picture side
// and three scan orders (zigzag, stride-1, stride-2) are supported.
//
// Optional feature macro: CONV_WIN_POS_EN adds OPU_POS_X/OPU_POS_Y/OPU_BIT.
//
// Ports:
//   SYS_CLK, SYS_RST      clock, asynchronous active-low reset
//   START                 one-cycle start pulse, sampled only in IDLE
//   PIC_SIZE, PADDING     picture side P (3..PIC_MAX), one-ring zero padding
//   MODE                  one-hot scan order: 001 zigzag, 010 stride-1, 100 stride-2
//   DATA, DATA_VLD, WREADY   input plane beats
//   OPU_DATA, OPU_VLD, OPU_RDY, OPU_LAST   window beats {m0..m8}, m0 in MSBs
//   BUSY, ERR             LOAD/SCAN activity, sticky configuration error
//   OPU_POS_X, OPU_POS_Y, OPU_BIT   window origin and plane (CONV_WIN_POS_EN)
`timescale 1ns/1ps
module conv_win_seq #(
    parameter int DW      = 128,
    parameter int PIC_MAX = 16,
    parameter int BITS    = 8
) (
    input  logic                            SYS_CLK,
    input  logic                            SYS_RST,
    input  logic                            START,
    input  logic [7:0]                      PIC_SIZE,
    input  logic                            PADDING,
    input  logic [2:0]                      MODE,
    input  logic [DW-1:0]                   DATA,
    input  logic                            DATA_VLD,
    output logic                            WREADY,
    output logic [9*DW-1:0]                 OPU_DATA,
    output logic                            OPU_VLD,
    input  logic                            OPU_RDY,
    output logic                            OPU_LAST,
    output logic                            BUSY,
    output logic                            ERR
`ifdef CONV_WIN_POS_EN
    ,
    output logic [7:0]                      OPU_POS_X,
    output logic [7:0]                      OPU_POS_Y,
    output logic [((BITS > 1) ? $clog2(BITS) : 1)-1:0] OPU_BIT
`endif
);

    localparam int DEPTH = PIC_MAX * PIC_MAX * BITS;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SCAN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [7:0]      psize_q, psize_d;
    logic            pad_q, pad_d;
    logic [2:0]      mode_q, mode_d;
    logic            err_q, err_d;
    logic [AW-1:0]   wcnt_q, wcnt_d;
    logic            prime_q, prime_d;
    logic            done_q, done_d;
    logic [BW-1:0]   b_q, b_d;
    logic            t_q, t_d;
    logic [7:0]      in_q, in_d;
    logic [7:0]      out_q, out_d;
    logic            vld_q, vld_d;
    logic            last_q, last_d;
    logic [9*DW-1:0] data_q, data_d;
`ifdef CONV_WIN_POS_EN
    logic [7:0]      posx_q, posx_d;
    logic [7:0]      posy_q, posy_d;
    logic [BW-1:0]   pbit_q, pbit_d;
`endif

    logic [DW-1:0]   mem [DEPTH];

    logic [7:0]      pad8, n, m, half, lim_in, lim_out, ox, oy;
    logic            col, cfg_ok, last_b, last_t, last_in, last_out, is_last, load;
    logic [AW-1:0]   wlast;
    logic [7:0]      px [9];
    logic [7:0]      py [9];
    logic            inr [9];
    logic [AW-1:0]   addr [9];
    logic [9*DW-1:0] win;

    assign cfg_ok = ((MODE == 3'b001) || (MODE == 3'b010) || (MODE == 3'b100)) &&
                    (PIC_SIZE >= 8'd3) && (PIC_SIZE <= 8'(PIC_MAX)) &&
                    !((MODE == 3'b001) && PIC_SIZE[0]);

    // Window origin and end-of-scan detection from the scan counters.
    // out_q: outer loop (x column, or zigzag strip), in_q: inner loop (y row),
    // t_q: left/right half of a zigzag strip row.
    always_comb begin : derive
        pad8    = {7'd0, pad_q};
        n       = psize_q - 8'd2 + {6'd0, pad_q, 1'b0};
        m       = (n + 8'd1) >> 1;
        half    = n >> 1;
        lim_in  = mode_q[2] ? m : n;
        lim_out = mode_q[0] ? half : lim_in;
        wlast   = AW'(int'(psize_q) * int'(psize_q) * BITS - 1);
        // Even strip rows go left-to-right, odd rows right-to-left.
        col     = in_q[0] ^ t_q;
        if (mode_q[1]) begin
            ox = out_q - pad8;
            oy = in_q - pad8;
        end else if (mode_q[2]) begin
            ox = (out_q << 1) - pad8;
            oy = (in_q << 1) - pad8;
        end else begin
            ox = (out_q << 1) + {7'd0, col} - pad8;
            oy = in_q - pad8;
        end
        last_b   = (b_q == BW'(BITS - 1));
        last_t   = !mode_q[0] || t_q;
        last_in  = (in_q == lim_in - 8'd1);
        last_out = (out_q == lim_out - 8'd1);
        is_last  = last_b && last_t && last_in && last_out;
    end

    // Gather the nine elements of the current window for plane b_q;
    // coordinates outside the picture read as zero.
    always_comb begin : gather
        win = '0;
        for (int k = 0; k < 9; k++) begin
            px[k]   = ox + 8'(k % 3);
            py[k]   = oy + 8'(k / 3);
            inr[k]  = ($signed(px[k]) >= 8'sd0) && ($signed(px[k]) < $signed(psize_q)) &&
                      ($signed(py[k]) >= 8'sd0) && ($signed(py[k]) < $signed(psize_q));
            addr[k] = inr[k] ? AW'((int'(py[k]) * int'(psize_q) + int'(px[k])) * BITS + int'(b_q))
                             : '0;
            if (inr[k]) begin
                win[(8-k)*DW +: DW] = mem[addr[k]];
            end
        end
    end

    always_comb begin : fsm
        state_d = state_q;
        psize_d = psize_q;
        pad_d   = pad_q;
        mode_d  = mode_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        prime_d = prime_q;
        done_d  = done_q;
        b_d     = b_q;
        t_d     = t_q;
        in_d    = in_q;
        out_d   = out_q;
        vld_d   = vld_q;
        last_d  = last_q;
        data_d  = data_q;
`ifdef CONV_WIN_POS_EN
        posx_d  = posx_q;
        posy_d  = posy_q;
        pbit_d  = pbit_q;
`endif
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (cfg_ok) begin
                        state_d = LOAD;
                        psize_d = PIC_SIZE;
                        pad_d   = PADDING;
                        mode_d  = MODE;
                        err_d   = 1'b0;
                        wcnt_d  = '0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (DATA_VLD) begin
                    wcnt_d = wcnt_q + AW'(1);
                    if (wcnt_q == wlast) begin
                        state_d = SCAN;
                        prime_d = 1'b0;
                        done_d  = 1'b0;
                        b_d     = '0;
                        t_d     = 1'b0;
                        in_d    = '0;
                        out_d   = '0;
                    end
                end
            end
            SCAN: begin
                // One idle cycle after LOAD before the first beat is registered.
                prime_d = 1'b1;
                load    = prime_q && !done_q && (!vld_q || OPU_RDY);
                if (load) begin
                    data_d = win;
                    vld_d  = 1'b1;
                    last_d = is_last;
                    done_d = is_last;
`ifdef CONV_WIN_POS_EN
                    posx_d = ox;
                    posy_d = oy;
                    pbit_d = b_q;
`endif
                    b_d = last_b ? '0 : b_q + BW'(1);
                    if (last_b) begin
                        if (mode_q[0]) begin
                            t_d = ~t_q;
                        end
                        if (last_t) begin
                            in_d = last_in ? 8'd0 : in_q + 8'd1;
                            if (last_in) begin
                                out_d = out_q + 8'd1;
                            end
                        end
                    end
                end else if (OPU_RDY) begin
                    vld_d = 1'b0;
                    if (vld_q && last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
        if (!SYS_RST) begin
            state_q <= IDLE;
            psize_q <= '0;
            pad_q   <= 1'b0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
            prime_q <= 1'b0;
            done_q  <= 1'b0;
            b_q     <= '0;
            t_q     <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
`ifdef CONV_WIN_POS_EN
            posx_q  <= '0;
            posy_q  <= '0;
            pbit_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            psize_q <= psize_d;
            pad_q   <= pad_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
            prime_q <= prime_d;
            done_q  <= done_d;
            b_q     <= b_d;
            t_q     <= t_d;
            in_q    <= in_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            data_q  <= data_d;
`ifdef CONV_WIN_POS_EN
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            pbit_q  <= pbit_d;
`endif
        end
    end

    // Picture store has no reset; the write counter restarts on every load.
    always_ff @(posedge SYS_CLK) begin
        if ((state_q == LOAD) && DATA_VLD) begin
            mem[wcnt_q] <= DATA;
        end
    end

    assign WREADY   = (state_q == LOAD);
    assign BUSY     = (state_q != IDLE);
    assign ERR      = err_q;
    assign OPU_VLD  = vld_q;
    assign OPU_LAST = last_q;
    assign OPU_DATA = data_q;
`ifdef CONV_WIN_POS_EN
    assign OPU_POS_X = posx_q;
    assign OPU_POS_Y = posy_q;
    assign OPU_BIT   = pbit_q;
`endif

endmodule

// File: doc/conv_win_seq.md
# conv_win_seq

Parametrised bit-plane 3x3 window sequencer feeding the OPU. It loads one square picture as bit-serial planes: each pixel arrives as BITS beats of DW lanes, LSB plane first. It then replays every 3x3 window as BITS beats of 9*DW bits under a valid/ready handshake. Zero padding, a programmable picture size and three scan orders are supported. It is the generalised successor of the fixed 128-lane / 8x8 SRAM-to-register path between the write interface and the OPU.

## Interface
- DW, 128, lanes per beat (channels)
- PIC_MAX, 16, maximum picture side; internal store holds PIC_MAX*PIC_MAX*BITS words of DW bits
- BITS, 8, bit planes per pixel
- SYS_CLK  in  1  clock
- SYS_RST  in  1  reset; one clock; reset is asynchronous and active-low
- START  in  1  one-cycle pulse; accepted only in IDLE; latches PIC_SIZE, PADDING, MODE
- PIC_SIZE  in  8  picture side P; legal range 3..PIC_MAX
- PADDING  in  1  p: 1 = one ring of zero pixels around the picture
- MODE  in  3  one-hot scan order: 001 zigzag, 010 stride-1, 100 stride-2
- DATA  in  DW  input plane beat
- DATA_VLD  in  1  input beat valid
- WREADY  out  1  input ready
- OPU_DATA  out  9*DW  window beat: {m0..m8}, m0 in MSBs
- OPU_VLD  out  1  output valid
- OPU_RDY  in  1  output ready
- OPU_LAST  out  1  marks the final beat of the final window
- BUSY  out  1  high in LOAD or SCAN
- ERR  out  1  configuration error, sticky until next START
- OPU_POS_X, OPU_POS_Y  out  8  window origin, two's complement (present only with CONV_WIN_POS_EN)
- OPU_BIT  out  $clog2(BITS)  current plane (present only with CONV_WIN_POS_EN)

## Operation
- States: IDLE, LOAD, SCAN.
- IDLE -> LOAD on START with a valid configuration.
- LOAD -> SCAN on the last input beat.
- SCAN -> IDLE on the OPU_LAST handshake.
- Invalid configuration means any of: MODE not one-hot, P<3, P>PIC_MAX, or MODE=001 with odd N. On invalid START the block sets ERR=1 and stays in IDLE.
- Input order is row-major by pixel. Each pixel is sent as BITS beats, plane 0 first. The beat for pixel (x,y), plane b, is stored at ((y*P+x)*BITS+b).
- Window origin (x,y) is the top-left corner. Elements are m0=(x,y), m1=(x+1,y), m2=(x+2,y), m3=(x,y+1) … m8=(x+2,y+2).
- Element k of a beat is {DW{1'b1}} masked by bit b of each lane of the stored word. Any coordinate outside 0..P-1 gives all-zero.
- Origins per axis: N = P-2+2p, starting at -p.
- MODE=010: x is the outer loop, y the inner loop; N*N windows.
- MODE=100: origins -p+2k for k=0..M-1, where M=(N+1)/2; x outer, y inner; M*M windows.
- MODE=001: the picture is cut into N/2 strips; strip s has x0 = 2s-p. Within a strip the order is (x0,y),(x0+1,y),(x0+1,y+1),(x0,y+1),(x0,y+2)…, snaking down the strip. N*N windows in total.
- Each window emits planes b=0..BITS-1 before the origin advances.
- Counters are sized for PIC_MAX. Coordinate arithmetic is 8-bit two's complement, and range checks are signed.

## Timing
- Reset values: WREADY=0, OPU_VLD=0, OPU_DATA=0, OPU_LAST=0, BUSY=0, ERR=0, position outputs 0; state is IDLE.
- WREADY=1 from the cycle after START until the last beat is accepted. It drops the cycle after that beat.
- An input beat is accepted on DATA_VLD&WREADY. DATA_VLD while WREADY=0 is ignored.
- OPU_DATA is registered. OPU_VLD rises 2 cycles after the last input handshake.
- A beat completes on OPU_VLD&OPU_RDY. With OPU_RDY held high, one beat is delivered per cycle.
- While OPU_VLD=1 and OPU_RDY=0, OPU_DATA, OPU_LAST and the position outputs are held stable.
- After the OPU_LAST handshake: OPU_VLD=0 and BUSY=0 on the next cycle.
- START is ignored in LOAD and SCAN.
- Reset asserted mid-LOAD or mid-SCAN returns all outputs to reset values immediately. Stored data is discarded.

## Configuration
- CONV_WIN_POS_EN defined: OPU_POS_X, OPU_POS_Y and OPU_BIT are present and registered alongside OPU_DATA.
- CONV_WIN_POS_EN undefined: these ports and their registers are absent. All other behaviour is identical.

## Test plan
- Stride-1 scan, P=8, p=1, MODE=010. Pixel (col c, row r) = r+8c. Expect N=8, 64 windows, 512 beats.
  - First beat: origin (-1,-1), plane 0. m7 and m8 are all-ones; all other elements are zero.
  - OPU_LAST appears only on beat 512.
- Backpressure on the same run: hold OPU_RDY=0 for 20 cycles mid-window. OPU_DATA and OPU_VLD stay constant; no beat is lost or repeated.
- Zigzag, P=8, p=1, MODE=001:
  - First four origins: (-1,-1),(0,-1),(0,0),(-1,0).
  - Strip 1 starts at x=1.
  - 64 windows in total.
- Stride-2, P=8, p=0, MODE=100: N=6, M=3. Expect 9 windows, origins (0,0),(0,2),(0,4),(2,0)…(4,4); 72 beats.
- Configuration errors:
  - P=7, p=0, MODE=001 (N=5, odd): ERR=1, WREADY stays 0, BUSY stays 0.
  - MODE=011: same response.
  - A following valid START clears ERR.
- Reset mid-operation: assert SYS_RST low during SCAN at beat 100. All outputs return to zero at once. A reload afterwards reproduces the first-scenario output exactly.
